// File: rtl/serial_word_tx_pkg.sv
// Shared types for the bit-serial word transmitter.
// Holds the FSM state encoding and the default word length.
package serial_word_tx_pkg;

   localparam int DEF_WIDTH = 64;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_word_tx_piso_shift_reg.sv
// Parallel-in serial-out register: load wins over shift, zero fill.
// Ports: clk, reset (sync, high), load, shift, d[WIDTH], q (bit 0).
module piso_shift_reg #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (reset)
         sr <= '0;
      else if (load)
         sr <= d;
      else if (shift)
         sr <= {1'b0, sr[WIDTH-1:1]};
   end

   assign q = sr[0];

endmodule

// File: rtl/serial_word_tx.sv
// Word to bit-serial transmitter, LSB first, valid/ready on both sides.
// Ports: clk, reset, in_data/in_valid/in_ready, ser_data/valid/last/ready, tx_done.
module serial_word_tx
   import serial_word_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_data,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             ser_ready,
   output logic             tx_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] count_q;
   logic          load;
   logic          shift;
   logic          done_d;
   logic          bit0;

   piso_shift_reg #(
      .WIDTH(WIDTH)
   ) u_sr (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .shift(shift),
      .d    (in_data),
      .q    (bit0)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // On the final beat in_ready opens so the next word
   // loads in the same edge and streams without a bubble.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_last  = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            ser_valid = 1'b1;
            ser_last  = (count_q == LAST);
            in_ready  = ser_last & ser_ready;
            if (ser_ready) begin
               shift = 1'b1;
               if (ser_last) begin
                  done_d = 1'b1;
                  if (in_valid)
                     load = 1'b1;
                  else
                     state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else if (load)
         count_q <= '0;
      else if (shift)
         count_q <= ser_last ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         tx_done <= 1'b0;
      else
         tx_done <= done_d;
   end

   assign ser_data = ser_valid & bit0;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx at WIDTH=8 and WIDTH=64.
// One linear initial block; immediate assertions at each check.
module tb_serial_word_tx;

   logic       clk = 1'b0;
   logic       reset;

   logic [7:0] a_data;
   logic       a_valid, a_ready, a_sd, a_sv, a_sl, a_sr, a_done;

   logic [63:0] b_data;
   logic        b_valid, b_ready, b_sd, b_sv, b_sl, b_sr, b_done;

   int vecs = 0;
   int errs = 0;

   logic [7:0]  w8;
   logic [7:0]  w8b;
   logic [63:0] w64;

   always #5 clk = ~clk;

   serial_word_tx #(.WIDTH(8)) d8 (
      .clk      (clk),
      .reset    (reset),
      .in_data  (a_data),
      .in_valid (a_valid),
      .in_ready (a_ready),
      .ser_data (a_sd),
      .ser_valid(a_sv),
      .ser_last (a_sl),
      .ser_ready(a_sr),
      .tx_done  (a_done)
   );

   serial_word_tx #(.WIDTH(64)) d64 (
      .clk      (clk),
      .reset    (reset),
      .in_data  (b_data),
      .in_valid (b_valid),
      .in_ready (b_ready),
      .ser_data (b_sd),
      .ser_valid(b_sv),
      .ser_last (b_sl),
      .ser_ready(b_sr),
      .tx_done  (b_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      reset   = 1'b1;
      a_data  = '0; a_valid = 1'b0; a_sr = 1'b0;
      b_data  = '0; b_valid = 1'b0; b_sr = 1'b0;

      // 1: reset held two cycles
      cyc(); cyc();
      reset = 1'b0;
      settle();
      chk("rst_in_ready", a_ready, 1);
      chk("rst_ser_valid", a_sv, 0);
      chk("rst_ser_data", a_sd, 0);
      chk("rst_ser_last", a_sl, 0);
      chk("rst_tx_done", a_done, 0);
      chk("rst64_in_ready", b_ready, 1);
      chk("rst64_ser_valid", b_sv, 0);

      // 2: single word A5, ready high
      w8 = 8'hA5;
      a_data = w8; a_valid = 1'b1; a_sr = 1'b1;
      settle();
      chk("t2_accept_ready", a_ready, 1);
      cyc();
      a_valid = 1'b0; a_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         settle();
         chk($sformatf("t2_valid%0d", i), a_sv, 1);
         chk($sformatf("t2_bit%0d", i), a_sd, w8[i]);
         chk($sformatf("t2_last%0d", i), a_sl, (i == 7));
         chk($sformatf("t2_inrdy%0d", i), a_ready, (i == 7));
         chk($sformatf("t2_done%0d", i), a_done, 0);
         cyc();
      end
      settle();
      chk("t2_done_pulse", a_done, 1);
      chk("t2_idle_valid", a_sv, 0);
      chk("t2_idle_ready", a_ready, 1);
      cyc();
      settle();
      chk("t2_done_clear", a_done, 0);

      // 3: backpressure, ready toggles 0/1 per bit
      w8 = 8'hC3;
      a_data = w8; a_valid = 1'b1; a_sr = 1'b1;
      cyc();
      a_valid = 1'b0; a_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         a_sr = 1'b0;
         settle();
         chk($sformatf("t3_hold_bit%0d", i), a_sd, w8[i]);
         chk($sformatf("t3_hold_valid%0d", i), a_sv, 1);
         chk($sformatf("t3_hold_last%0d", i), a_sl, (i == 7));
         chk($sformatf("t3_hold_inrdy%0d", i), a_ready, 0);
         cyc();
         a_sr = 1'b1;
         settle();
         chk($sformatf("t3_beat_bit%0d", i), a_sd, w8[i]);
         chk($sformatf("t3_beat_inrdy%0d", i), a_ready, (i == 7));
         cyc();
      end
      settle();
      chk("t3_done", a_done, 1);
      chk("t3_idle_valid", a_sv, 0);

      // 4: back-to-back FF then 01, in_valid held
      w8 = 8'hFF; w8b = 8'h01;
      a_data = w8; a_valid = 1'b1; a_sr = 1'b1;
      cyc();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) a_data = w8b;
         settle();
         chk($sformatf("t4_w0_valid%0d", i), a_sv, 1);
         chk($sformatf("t4_w0_bit%0d", i), a_sd, w8[i]);
         chk($sformatf("t4_w0_inrdy%0d", i), a_ready, (i == 7));
         cyc();
      end
      a_valid = 1'b0; a_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         settle();
         chk($sformatf("t4_w1_valid%0d", i), a_sv, 1);
         chk($sformatf("t4_w1_bit%0d", i), a_sd, w8b[i]);
         chk($sformatf("t4_w1_last%0d", i), a_sl, (i == 7));
         chk($sformatf("t4_w1_done%0d", i), a_done, (i == 0));
         cyc();
      end
      settle();
      chk("t4_done", a_done, 1);
      chk("t4_idle_valid", a_sv, 0);

      // 6: in_data/in_valid changing mid-word is ignored
      w8 = 8'h96;
      a_data = w8; a_valid = 1'b1; a_sr = 1'b1;
      cyc();
      a_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) a_valid = 1'b0;
         settle();
         chk($sformatf("t6_bit%0d", i), a_sd, w8[i]);
         chk($sformatf("t6_inrdy%0d", i), a_ready, (i == 7));
         cyc();
      end
      settle();
      chk("t6_done", a_done, 1);
      chk("t6_idle", a_sv, 0);

      // 5: WIDTH=64, reset at beat 20, then word 1
      w64 = 64'hDEADBEEF_01234567;
      b_data = w64; b_valid = 1'b1; b_sr = 1'b1;
      cyc();
      b_valid = 1'b0; b_data = '0;
      for (int i = 0; i < 20; i++) begin
         settle();
         chk($sformatf("t5_bit%0d", i), b_sd, w64[i]);
         chk($sformatf("t5_last%0d", i), b_sl, 0);
         cyc();
      end
      settle();
      chk("t5_pre_rst_valid", b_sv, 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      settle();
      chk("t5_rst_valid", b_sv, 0);
      chk("t5_rst_data", b_sd, 0);
      chk("t5_rst_last", b_sl, 0);
      chk("t5_rst_ready", b_ready, 1);
      chk("t5_rst_done", b_done, 0);
      cyc();
      settle();
      chk("t5_rst_done2", b_done, 0);
      w64 = 64'h1;
      b_data = w64; b_valid = 1'b1;
      cyc();
      b_valid = 1'b0; b_data = '0;
      for (int i = 0; i < 64; i++) begin
         settle();
         chk($sformatf("t5_w1_valid%0d", i), b_sv, 1);
         chk($sformatf("t5_w1_bit%0d", i), b_sd, w64[i]);
         chk($sformatf("t5_w1_last%0d", i), b_sl, (i == 63));
         cyc();
      end
      settle();
      chk("t5_w1_done", b_done, 1);
      chk("t5_w1_idle", b_sv, 0);
      cyc();
      settle();
      chk("t5_w1_done_clear", b_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
